// File: rtl/mfcc_frame_sequencer.sv
// MFCC frame sequencer: issues window moves and drains FRAME_SIZE samples per frame onto a
// registered valid/ready stream. Optional stall watchdog enabled by MFCC_SEQ_WATCHDOG_EN.
module mfcc_frame_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAME_SIZE  = 306,
  parameter int unsigned MOVE_SIZE   = 123,
  parameter int unsigned FRAME_IDX_W = 16,
  parameter int unsigned WDOG_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  output logic                   wb_start_move_o,
  input  logic                   wb_next_state_i,
  output logic                   wb_rd_en_o,
  input  logic [WIDTH-1:0]       wb_read_data_i,
  input  logic                   wb_valid_i,
  output logic [WIDTH-1:0]       frame_data_o,
  output logic                   frame_valid_o,
  input  logic                   frame_ready_i,
  output logic                   frame_first_o,
  output logic                   frame_last_o,
  output logic [FRAME_IDX_W-1:0] frame_idx_o,
  output logic                   frame_done_o,
  output logic                   busy_o,
  output logic                   err_timeout_o
);

  localparam int unsigned CntW = $clog2(FRAME_SIZE + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_SIZE);
  localparam logic [CntW-1:0] CntLast = CntW'(FRAME_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StMove, StWaitAck, StStream} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        sample_cnt_q;
  logic                   first_frame_q;
  logic [WIDTH-1:0]       data_q;
  logic                   valid_q;
  logic                   first_q;
  logic                   last_q;
  logic                   move_q;
  logic                   done_q;
  logic [FRAME_IDX_W-1:0] frame_idx_q;

  logic rd_en;
  logic out_hs;
  logic last_hs;
  logic wdog_fire;

  // A read only happens when the output register is empty or draining this cycle.
  assign rd_en = (state_q == StStream) && wb_valid_i && (sample_cnt_q < CntMax) &&
                 (!valid_q || frame_ready_i);
  assign out_hs  = valid_q && frame_ready_i;
  assign last_hs = (state_q == StStream) && out_hs && last_q;

`ifdef MFCC_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);

  logic [WdW-1:0] wdog_q;
  logic           err_q;
  logic           stall;

  assign stall = ((state_q == StStream) && (sample_cnt_q < CntMax) && !wb_valid_i) ||
                 ((state_q == StWaitAck) && !wb_next_state_i);
  assign wdog_fire = stall && (wdog_q == WdW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wdog_fire) begin
        wdog_q <= '0;
        err_q  <= 1'b1;
      end else if (stall) begin
        wdog_q <= wdog_q + WdW'(1);
      end else begin
        wdog_q <= '0;
      end
      if ((state_q == StIdle) && !enable_i) begin
        err_q <= 1'b0;
      end
    end
  end

  assign err_timeout_o = err_q;
`else
  assign wdog_fire     = 1'b0;
  assign err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      sample_cnt_q  <= '0;
      first_frame_q <= 1'b1;
      data_q        <= '0;
      valid_q       <= 1'b0;
      first_q       <= 1'b0;
      last_q        <= 1'b0;
      move_q        <= 1'b0;
      done_q        <= 1'b0;
      frame_idx_q   <= '0;
    end else begin
      move_q <= 1'b0;
      done_q <= 1'b0;
      // Index advances the cycle after the done pulse so the pulse still reports the old frame.
      if (done_q) begin
        frame_idx_q <= frame_idx_q + FRAME_IDX_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q <= first_frame_q ? StStream : StMove;
          end
        end
        StMove: begin
          move_q  <= 1'b1;
          state_q <= StWaitAck;
        end
        StWaitAck: begin
          if (wb_next_state_i) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (rd_en) begin
            data_q       <= wb_read_data_i;
            valid_q      <= 1'b1;
            first_q      <= (sample_cnt_q == '0);
            last_q       <= (sample_cnt_q == CntLast);
            sample_cnt_q <= sample_cnt_q + CntW'(1);
          end else if (out_hs) begin
            valid_q <= 1'b0;
          end
          if (last_hs) begin
            done_q        <= 1'b1;
            sample_cnt_q  <= '0;
            first_frame_q <= 1'b0;
            state_q       <= enable_i ? StMove : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Timeout abandons the partial frame but keeps the frame index.
      if (wdog_fire) begin
        state_q      <= StIdle;
        valid_q      <= 1'b0;
        sample_cnt_q <= '0;
      end
    end
  end

  assign wb_start_move_o = move_q;
  assign wb_rd_en_o      = rd_en;
  assign frame_data_o    = data_q;
  assign frame_valid_o   = valid_q;
  assign frame_first_o   = first_q;
  assign frame_last_o    = last_q;
  assign frame_idx_o     = frame_idx_q;
  assign frame_done_o    = done_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_mfcc_frame_sequencer.sv
// Self-checking bench for mfcc_frame_sequencer: a directed vector table, directed frame
// scenarios and randomized frames checked against a sample-sequence scoreboard.
module tb_mfcc_frame_sequencer;

  localparam int W  = 16;
  localparam int FS = 306;
  localparam int IW = 16;
`ifdef MFCC_SEQ_WATCHDOG_EN
  localparam int WD  = 16;
  localparam int GAP = 12;
`else
  localparam int WD  = 4096;
  localparam int GAP = 20;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_i = 1'b0;
  logic          wb_start_move_o;
  logic          wb_next_state_i = 1'b0;
  logic          wb_rd_en_o;
  logic [W-1:0]  wb_read_data_i = '0;
  logic          wb_valid_i = 1'b0;
  logic [W-1:0]  frame_data_o;
  logic          frame_valid_o;
  logic          frame_ready_i = 1'b0;
  logic          frame_first_o;
  logic          frame_last_o;
  logic [IW-1:0] frame_idx_o;
  logic          frame_done_o;
  logic          busy_o;
  logic          err_timeout_o;

  always #5 clk = ~clk;

  mfcc_frame_sequencer #(
    .WIDTH      (W),
    .FRAME_SIZE (FS),
    .MOVE_SIZE  (123),
    .FRAME_IDX_W(IW),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .wb_start_move_o(wb_start_move_o),
    .wb_next_state_i(wb_next_state_i),
    .wb_rd_en_o     (wb_rd_en_o),
    .wb_read_data_i (wb_read_data_i),
    .wb_valid_i     (wb_valid_i),
    .frame_data_o   (frame_data_o),
    .frame_valid_o  (frame_valid_o),
    .frame_ready_i  (frame_ready_i),
    .frame_first_o  (frame_first_o),
    .frame_last_o   (frame_last_o),
    .frame_idx_o    (frame_idx_o),
    .frame_done_o   (frame_done_o),
    .busy_o         (busy_o),
    .err_timeout_o  (err_timeout_o)
  );

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: the buffer serves sample k of frame f as val(f,k); the stream must
  // deliver every frame's samples in order with first/last tags and the frame number.
  int buf_frame, buf_k, exp_frame, exp_k;
  int cyc, beats_total, frames_done, moves;
  int last_done_cyc, last_move_cyc, first_beat_cyc, last_beat_cyc;
  bit gate_open, move_ok, awaiting, done_exp, sb_on, en_idle_watch;

  function automatic logic [W-1:0] val(input int f, input int k);
    return {f[6:0], k[8:0]};
  endfunction

  task automatic sb_reset();
    buf_frame = 0; buf_k = 0; exp_frame = 0; exp_k = 0;
    gate_open = 1; move_ok = 0; awaiting = 0; done_exp = 0;
    wb_read_data_i = val(0, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable_i = 0; wb_valid_i = 0; frame_ready_i = 0; wb_next_state_i = 0;
    repeat (2) @(posedge clk);
    #1;
    sb_reset();
    rst_n = 1'b1;
  endtask

  // One clock: observe at the falling edge, update the buffer model after the rising edge.
  task automatic cycle();
    bit rd, hs, mv, allowed, done_next;
    @(negedge clk);
    cyc++;
    rd = wb_rd_en_o && wb_valid_i;
    hs = frame_valid_o && frame_ready_i;
    mv = wb_start_move_o;
    done_next = 0;
    if (sb_on) begin
      chk("done_pulse", frame_done_o, done_exp);
      if (frame_done_o) last_done_cyc = cyc;
      allowed = gate_open && wb_valid_i && (buf_k < FS) && (!frame_valid_o || frame_ready_i);
      chk("rd_en_legal", wb_rd_en_o & ~allowed, 0);
      chk("move_legal", mv & ~move_ok, 0);
      if (en_idle_watch) chk("no_move_disabled", mv, 0);
      if (frame_valid_o) begin
        chk("beat_data", frame_data_o, val(exp_frame, exp_k));
        chk("beat_tags", {frame_first_o, frame_last_o}, {exp_k == 0, exp_k == FS - 1});
        chk("beat_idx", frame_idx_o, exp_frame[IW-1:0]);
      end
      if (hs) begin
        beats_total++;
        if (exp_k == 0) first_beat_cyc = cyc;
        if (exp_k == FS - 1) begin
          exp_k = 0; exp_frame++; frames_done++;
          move_ok = 1; gate_open = 0; done_next = 1; last_beat_cyc = cyc;
        end else begin
          exp_k++;
        end
      end
      done_exp = done_next;
      if (mv) begin
        moves++; last_move_cyc = cyc; move_ok = 0; awaiting = 1;
        buf_frame++; buf_k = 0;
      end
      if (wb_next_state_i && awaiting) begin
        awaiting = 0; gate_open = 1;
      end
    end
    if (rd) buf_k++;
    @(posedge clk);
    #1;
    wb_read_data_i = val(buf_frame, buf_k);
    wb_next_state_i = 1'b0;
  endtask

  // Modes: 0 full rate, 1 ready toggling, 2 valid gap at sample 100, 3 enable drop at 50,
  // 4 random.
  task automatic run_frame(input int mode, input int ack_delay, input int expect_move,
                           input string tag);
    int f0, m0, b0, wait_cnt, gap, n;
    f0 = frames_done; m0 = moves; b0 = beats_total; wait_cnt = 0; gap = 0; n = 0;
    while (frames_done == f0 && n < 3000) begin
      case (mode)
        0: begin enable_i = 1; wb_valid_i = 1; frame_ready_i = 1; end
        1: begin enable_i = 1; wb_valid_i = 1; frame_ready_i = n[0]; end
        2: begin
          enable_i = 1; frame_ready_i = 1;
          if (buf_k == 100 && gap < GAP) begin
            wb_valid_i = 0; gap++;
          end else begin
            wb_valid_i = 1;
          end
        end
        3: begin
          wb_valid_i = 1; frame_ready_i = 1;
          enable_i = !(moves > m0 && buf_k >= 50);
        end
        default: begin
          wb_valid_i = ($urandom_range(0, 3) != 0);
          frame_ready_i = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 19) == 0) enable_i = !enable_i;
        end
      endcase
      if (awaiting) begin
        if (wait_cnt == ack_delay) wb_next_state_i = 1;
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (mode == 4) wb_next_state_i = ($urandom_range(0, 15) == 0);
      end
      cycle();
      n++;
    end
    chk({tag, "_done"}, frames_done - f0, 1);
    chk({tag, "_beats"}, beats_total - b0, FS);
    chk({tag, "_moves"}, moves - m0, expect_move);
  endtask

  typedef struct {
    bit en, vld, rdy;
    logic [W-1:0] din;
    bit e_rd, e_fv, e_first, e_last, e_busy;
    logic [W-1:0] e_data;
  } tvec_t;

  tvec_t tv[9];

  initial begin
    tv[0] = '{0, 1, 1, 16'hA000, 0, 0, 0, 0, 0, 16'h0000};
    tv[1] = '{1, 1, 1, 16'hA001, 0, 0, 0, 0, 0, 16'h0000};
    tv[2] = '{1, 1, 1, 16'hD000, 1, 0, 0, 0, 1, 16'h0000};
    tv[3] = '{1, 0, 0, 16'hD001, 0, 1, 1, 0, 1, 16'hD000};
    tv[4] = '{1, 1, 0, 16'hD001, 0, 1, 1, 0, 1, 16'hD000};
    tv[5] = '{1, 1, 1, 16'hD001, 1, 1, 1, 0, 1, 16'hD000};
    tv[6] = '{1, 1, 1, 16'hD002, 1, 1, 0, 0, 1, 16'hD001};
    tv[7] = '{1, 0, 1, 16'hD003, 0, 1, 0, 0, 1, 16'hD002};
    tv[8] = '{1, 0, 1, 16'hD003, 0, 0, 0, 0, 1, 16'hD002};

    cyc = 0; beats_total = 0; frames_done = 0; moves = 0;
    last_done_cyc = 0; last_move_cyc = 0; first_beat_cyc = 0; last_beat_cyc = 0;
    sb_on = 0; en_idle_watch = 0;

    apply_reset();
    @(negedge clk);
    chk("reset_outputs", {wb_start_move_o, wb_rd_en_o, frame_data_o, frame_valid_o,
        frame_first_o, frame_last_o, frame_idx_o, frame_done_o, busy_o, err_timeout_o}, 0);
    @(posedge clk);
    #1;

    foreach (tv[i]) begin
      enable_i = tv[i].en; wb_valid_i = tv[i].vld; frame_ready_i = tv[i].rdy;
      wb_read_data_i = tv[i].din;
      @(negedge clk);
      chk($sformatf("tv%0d_rd_en", i), wb_rd_en_o, tv[i].e_rd);
      chk($sformatf("tv%0d_valid", i), frame_valid_o, tv[i].e_fv);
      chk($sformatf("tv%0d_first_last", i), {frame_first_o, frame_last_o},
          {tv[i].e_first, tv[i].e_last});
      chk($sformatf("tv%0d_busy", i), busy_o, tv[i].e_busy);
      chk($sformatf("tv%0d_move_done", i), {wb_start_move_o, frame_done_o}, 0);
      if (tv[i].e_fv) chk($sformatf("tv%0d_data", i), frame_data_o, tv[i].e_data);
      @(posedge clk);
      #1;
    end

    // Full-rate first frame, then the move/ack handshake.
    apply_reset();
    sb_on = 1;
    run_frame(0, 0, 0, "f1");
    chk("f1_span", last_beat_cyc - first_beat_cyc, FS - 1);
    for (int i = 0; i < 5 && moves == 0; i++) cycle();
    chk("move_one_after_done", last_move_cyc - last_done_cyc, 1);
    cycle();
    chk("idx_after_frame", frame_idx_o, 1);
    run_frame(0, 3, 0, "f2");
    chk("f2_single_move", moves, 1);

    run_frame(1, 2, 1, "ready_toggle");
    run_frame(2, 1, 1, "valid_gap");

    run_frame(3, 2, 1, "enable_drop");
    en_idle_watch = 1;
    repeat (10) cycle();
    chk("idle_after_drop", busy_o, 0);
    chk("idle_moves", moves, 4);
    en_idle_watch = 0;
    run_frame(0, 2, 1, "reenable");

    for (int f = 0; f < 4; f++) run_frame(4, $urandom_range(0, 6), 1, $sformatf("rand%0d", f));

    // Asynchronous reset in the middle of a frame.
    enable_i = 1; wb_valid_i = 1; frame_ready_i = 1;
    for (int i = 0; i < 60 && !(buf_k >= 10 && buf_k < FS); i++) begin
      if (awaiting) wb_next_state_i = 1;
      cycle();
    end
    chk("mid_frame_reached", frame_valid_o, 1);
    sb_on = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {wb_start_move_o, wb_rd_en_o, frame_data_o, frame_valid_o,
        frame_first_o, frame_last_o, frame_idx_o, frame_done_o, busy_o, err_timeout_o}, 0);

    // Stall in STREAM with no buffer data.
    apply_reset();
    enable_i = 1; wb_valid_i = 0; frame_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy_o) break;
    end
    chk("stall_busy", busy_o, 1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) chk("wdog_not_yet", err_timeout_o, 0);
    end
`ifdef MFCC_SEQ_WATCHDOG_EN
    chk("wdog_err", err_timeout_o, 1);
    chk("wdog_idle", busy_o, 0);
    enable_i = 0;
    @(negedge clk);
    chk("wdog_clear", err_timeout_o, 0);
`else
    chk("no_wdog_err", err_timeout_o, 0);
    chk("no_wdog_busy", busy_o, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mfcc_frame_sequencer.md
Name: mfcc_frame_sequencer

Overview:
Controller that sequences the MFCC sliding-window buffer. It issues window advances and drains exactly FRAME_SIZE samples per frame from the buffer. Drained samples go through a registered valid/ready stream, tagged with first/last markers and a frame index. It sits between the window buffer and the windowing/FFT stage and owns all buffer read and advance control.

Parameters:
WIDTH, 16, sample width in bits
FRAME_SIZE, 306, samples per frame
MOVE_SIZE, 123, hop size in samples; informational only, the buffer applies it
FRAME_IDX_W, 16, frame index counter width
WDOG_CYCLES, 4096, watchdog stall limit; used only with the optional feature

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
enable_i  input  1  run request; level-sensitive
wb_start_move_o  output  1  one-cycle pulse that advances the window by one hop
wb_next_state_i  input  1  buffer pulse: refill started after reset or after a move
wb_rd_en_o  output  1  buffer read strobe
wb_read_data_i  input  WIDTH  buffer sample at current read position
wb_valid_i  input  1  buffer has a readable sample
frame_data_o  output  WIDTH  registered sample to downstream
frame_valid_o  output  1  frame_data_o is valid
frame_ready_i  input  1  downstream accepts
frame_first_o  output  1  sample is index 0 of the frame
frame_last_o  output  1  sample is index FRAME_SIZE-1
frame_idx_o  output  FRAME_IDX_W  index of the frame being streamed
frame_done_o  output  1  one-cycle pulse when the last sample is accepted downstream
busy_o  output  1  high in any state except IDLE
err_timeout_o  output  1  watchdog error, sticky (optional feature)

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; sample_cnt 0; frame_idx 0.
  - first_frame flag = 1.
- Reset mid-operation aborts immediately. No move pulse is issued and no pending data is flushed.
- State machine:
  - IDLE: if enable_i, go to STREAM when first_frame=1, else go to MOVE. The buffer self-fills the first frame after reset.
  - MOVE: assert wb_start_move_o for exactly 1 cycle, then go to WAIT_ACK.
  - WAIT_ACK: wait for a wb_next_state_i pulse, then go to STREAM. A pulse arriving in the same cycle as MOVE is not counted.
  - STREAM:
    - wb_rd_en_o = wb_valid_i && sample_cnt < FRAME_SIZE && (!frame_valid_o || frame_ready_i). This is combinational.
    - A read is accepted when wb_rd_en_o && wb_valid_i. On accept: capture wb_read_data_i into frame_data_o, set frame_valid_o, set first = (sample_cnt==0), set last = (sample_cnt==FRAME_SIZE-1), then sample_cnt++.
    - If frame_ready_i && frame_valid_o with no new accept, clear frame_valid_o.
    - When the last sample handshakes downstream:
      - pulse frame_done_o;
      - frame_idx wraps modulo 2^FRAME_IDX_W; it increments in the cycle after the frame_done_o pulse;
      - clear sample_cnt and first_frame;
      - go to MOVE if enable_i, else IDLE.
- Latency: buffer accept to frame_valid_o is 1 cycle. Full throughput is 1 sample/cycle when ready is held high.
- Back-pressure: frame_ready_i low holds frame_data_o and all tags stable. wb_rd_en_o stays low while the output register is full and not draining.
- Frame boundary:
  - No read of frame N+1 is issued until frame N's last sample is accepted downstream and the move/ack handshake completes.
  - wb_rd_en_o is never asserted outside STREAM.
- Deasserting enable_i mid-frame does not truncate: the current frame completes, then the block goes to IDLE.
- Re-enabling from IDLE with first_frame=0 issues a MOVE first.
- wb_next_state_i outside WAIT_ACK is ignored.

Optional Feature:
Macro MFCC_SEQ_WATCHDOG_EN.
- Defined:
  - A stall counter counts consecutive STREAM cycles with sample_cnt<FRAME_SIZE and wb_valid_i=0, and consecutive WAIT_ACK cycles without wb_next_state_i.
  - The counter clears on any accept or ack.
  - On reaching WDOG_CYCLES: set err_timeout_o (sticky) and force the state to IDLE, keeping frame_idx.
  - err_timeout_o clears only on reset, or on enable_i low for 1 cycle while in IDLE.
- Undefined: no counter; err_timeout_o is tied 0.

Test Plan:
1. Reset release, enable_i=1, wb_valid_i=1, ready=1 -> 306 consecutive frame_valid_o cycles; first on sample 0, last on sample 305; frame_done_o pulses once; frame_idx_o=0 during the frame, then 1; no wb_start_move_o before frame_done_o.
2. Frame 2 -> wb_start_move_o single pulse 1 cycle after frame_done_o; no wb_rd_en_o until a wb_next_state_i pulse is supplied 5 cycles later; streaming then resumes.
3. frame_ready_i toggling 1-0-1 every cycle -> frame_data_o stable while ready=0; exactly 306 unique samples delivered, none duplicated or dropped.
4. wb_valid_i low for 20 cycles at sample 100 -> wb_rd_en_o low throughout; stream resumes at sample 100; total still 306.
5. enable_i dropped at sample 50 -> frame completes at 306; state goes to IDLE with no wb_start_move_o. Re-enable -> move pulse precedes the next frame.
6. MFCC_SEQ_WATCHDOG_EN with WDOG_CYCLES=16, wb_valid_i held 0 in STREAM -> err_timeout_o=1 after 16 cycles and busy_o=0. Async reset mid-frame -> all outputs 0 in the same cycle.
